// File: rtl/ysyx_22050598_idu_pkg.sv
// Shared IDU constants: RISC-V major opcodes, one-hot instruction types,
// the EBREAK encoding and the per-entry decoded field record.
package ysyx_22050598_idu_pkg;

    localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
    localparam logic [6:0] OPCODE_ALU_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_ALU_REG   = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPCODE_ALU_IMM32 = 7'b0011011;
    localparam logic [6:0] OPCODE_ALU_REG32 = 7'b0111011;

    localparam logic [5:0] INST_TYPE_R = 6'b100000;
    localparam logic [5:0] INST_TYPE_I = 6'b010000;
    localparam logic [5:0] INST_TYPE_S = 6'b001000;
    localparam logic [5:0] INST_TYPE_B = 6'b000100;
    localparam logic [5:0] INST_TYPE_U = 6'b000010;
    localparam logic [5:0] INST_TYPE_J = 6'b000001;
    localparam logic [5:0] INST_TYPE_N = 6'b000000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [6:0] opcode;
        logic [5:0] inst_type;
        logic       illegal;
        logic       ebreak;
    } dec_fields_t;

endpackage

// File: rtl/ysyx_22050598_idu_dec.sv
// Combinational RISC-V decoder: instruction class, one-hot type, immediates
// extended to XLEN, illegal and ebreak flags.
module ysyx_22050598_idu_dec
    import ysyx_22050598_idu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit RV64_OPS = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [5:0]      inst_type,
    output logic            illegal,
    output logic            ebreak,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] imm_u
);

    localparam bit WIDE_OPS = RV64_OPS && (XLEN == 64);

    logic [31:0] imm_s32;
    logic [31:0] imm_u32;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the cases infers a latch.
        inst_type = INST_TYPE_N;
        imm_s32   = '0;
        imm_u32   = '0;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OPCODE_LUI, OPCODE_AUIPC: inst_type = INST_TYPE_U;
                OPCODE_JAL:               inst_type = INST_TYPE_J;
                OPCODE_JALR, OPCODE_LOAD,
                OPCODE_ALU_IMM, OPCODE_SYSTEM: inst_type = INST_TYPE_I;
                OPCODE_ALU_IMM32: if (WIDE_OPS) inst_type = INST_TYPE_I;
                OPCODE_BRANCH:    inst_type = INST_TYPE_B;
                OPCODE_STORE:     inst_type = INST_TYPE_S;
                OPCODE_ALU_REG:   inst_type = INST_TYPE_R;
                OPCODE_ALU_REG32: if (WIDE_OPS) inst_type = INST_TYPE_R;
                default: ;
            endcase
        end

        // imm_s32 carries the field sign-extended to 32 bits, imm_u32 zero-extended.
        case (inst_type)
            INST_TYPE_I: begin
                imm_u32 = {20'b0, inst[31:20]};
                imm_s32 = {{20{inst[31]}}, inst[31:20]};
            end
            INST_TYPE_S: begin
                imm_u32 = {20'b0, inst[31:25], inst[11:7]};
                imm_s32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            INST_TYPE_B: begin
                imm_u32 = {19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                imm_s32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            INST_TYPE_U: begin
                imm_u32 = {inst[31:12], 12'b0};
                imm_s32 = {inst[31:12], 12'b0};
            end
            INST_TYPE_J: begin
                imm_u32 = {11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                imm_s32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign illegal = (inst_type == INST_TYPE_N);
    assign ebreak  = (inst == INST_EBREAK);
    assign imm     = XLEN'(signed'(imm_s32));
    assign imm_u   = XLEN'(imm_u32);

endmodule

// File: rtl/ysyx_22050598_idu_pipe.sv
// Registered decode stage: decodes on enqueue into a DEPTH-entry FIFO of
// decoded records, with valid/ready on both sides and a redirect flush.
module ysyx_22050598_idu_pipe
    import ysyx_22050598_idu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 2,
    parameter bit RV64_OPS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_immU,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [6:0]      out_opcode,
    output logic [5:0]      out_inst_type,
    output logic            out_illegal,
    output logic            out_ebreak
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] imm_u;
        dec_fields_t     fields;
    } entry_t;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    entry_t           new_entry;
    entry_t           head;
    logic             push;
    logic             pop;
    logic [5:0]       dec_type;
    logic             dec_illegal;
    logic             dec_ebreak;
    logic [XLEN-1:0]  dec_imm;
    logic [XLEN-1:0]  dec_imm_u;

    ysyx_22050598_idu_dec #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_dec (
        .inst      (in_inst),
        .inst_type (dec_type),
        .illegal   (dec_illegal),
        .ebreak    (dec_ebreak),
        .imm       (dec_imm),
        .imm_u     (dec_imm_u)
    );

    assign new_entry.pc               = in_pc;
    assign new_entry.imm              = dec_imm;
    assign new_entry.imm_u            = dec_imm_u;
    assign new_entry.fields.rs1       = in_inst[19:15];
    assign new_entry.fields.rs2       = in_inst[24:20];
    assign new_entry.fields.rd        = in_inst[11:7];
    assign new_entry.fields.funct3    = in_inst[14:12];
    assign new_entry.fields.funct7    = in_inst[31:25];
    assign new_entry.fields.opcode    = in_inst[6:0];
    assign new_entry.fields.inst_type = dec_type;
    assign new_entry.fields.illegal   = dec_illegal;
    assign new_entry.fields.ebreak    = dec_ebreak;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on count, so a full queue refuses a push even while popping.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // NOTE: storage has no reset; outputs are forced to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_pc        = head.pc;
    assign out_imm       = head.imm;
    assign out_immU      = head.imm_u;
    assign out_rs1       = head.fields.rs1;
    assign out_rs2       = head.fields.rs2;
    assign out_rd        = head.fields.rd;
    assign out_funct3    = head.fields.funct3;
    assign out_funct7    = head.fields.funct7;
    assign out_opcode    = head.fields.opcode;
    assign out_inst_type = head.fields.inst_type;
    assign out_illegal   = head.fields.illegal;
    assign out_ebreak    = head.fields.ebreak;

endmodule
